cve2_regfile_wb: RTL
====================

# cve2_regfile_wb

Flip-flop integer register file that sinks the writeback port (address, data, write-enable) driven by the core's writeback passthrough. It exposes two combinational read ports to the ID stage. It also contains a single-entry load scoreboard that flags read-after-load hazards until the LSU response for the outstanding load arrives. It sits between the writeback logic and the decoder/operand muxes in ID.

## Interface
Parameters:
- RV32E, default 0; 1 = 16 architectural registers (x0–x15), 0 = 32 registers.
- DataWidth, default 32; register width.

Ports:
- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- rf_waddr_wb_i  in  5  write address from writeback.
- rf_wdata_wb_i  in  DataWidth  write data from writeback.
- rf_we_wb_i  in  1  write enable from writeback.
- rf_raddr_a_i / rf_raddr_b_i  in  5  read addresses.
- rf_rdata_a_o / rf_rdata_b_o  out  DataWidth  read data.
- load_issue_i  in  1  ID issues a load this cycle.
- load_waddr_i  in  5  destination register of the issued load.
- lsu_resp_valid_i  in  1  LSU response for the outstanding load.
- lsu_resp_err_i  in  1  that response is an error (no RF write follows).
- load_pending_o  out  1  scoreboard holds an outstanding load.
- hazard_a_o / hazard_b_o  out  1  read port addresses the pending load's destination.
- wr_err_o  out  1  one-cycle pulse: write to a nonexistent register (RV32E only).
- issue_err_o  out  1  one-cycle pulse: load issued while one is already pending and not resolving.

## Operation
- Storage:
  - x0 reads 0 and is never written; writes to x0 are silently dropped.
  - Registers x1..N-1 are written on the edge where rf_we_wb_i=1.
- RV32E=1:
  - Writes with rf_waddr_wb_i[4]=1 are dropped and pulse wr_err_o the next cycle.
  - Reads with addr[4]=1 return 0.
- Reads are combinational from the register array, plus forwarding when the configuration macro is defined.
- Scoreboard FSM, states IDLE and PEND:
  - IDLE, load_issue_i=1: go to PEND; capture pend_addr ← load_waddr_i.
  - PEND, lsu_resp_valid_i=1 with load_issue_i=0: go to IDLE.
  - PEND, lsu_resp_valid_i=1 with load_issue_i=1 (back-to-back): stay in PEND; pend_addr ← load_waddr_i.
  - PEND, load_issue_i=1 with lsu_resp_valid_i=0: issue dropped, pend_addr unchanged, issue_err_o pulses the next cycle.
  - lsu_resp_err_i only qualifies the write; the FSM still resolves on lsu_resp_valid_i regardless of error.
- load_pending_o = (state==PEND).
- hazard_x_o = PEND & (rf_raddr_x_i==pend_addr) & (pend_addr!=0). It is combinational in the read address.
- A hazard is cleared in the cycle lsu_resp_valid_i=1 only if forwarding is compiled in; otherwise it clears the cycle after.
- Simultaneous writeback write and load issue to the same address: the write lands, and the scoreboard still marks that address pending.

## Timing
- Reset (rst_i high at an edge):
  - all registers ← 0; state ← IDLE; pend_addr ← 0; wr_err_o=0; issue_err_o=0.
  - Read outputs are therefore 0 and hazards 0 after reset.
  - Reset while in PEND discards the pending load.
- Write latency: visible on read ports the cycle after the write edge (0 cycles with forwarding).
- wr_err_o and issue_err_o are registered and last exactly 1 cycle per event.
- Reads have no handshake and are valid in the same cycle as the address.

## Configuration
- CVE2_RF_FWD_EN defined:
  - rf_rdata_x_o = rf_wdata_wb_i when rf_we_wb_i & rf_waddr_wb_i==rf_raddr_x_i & addr!=0 (and, for RV32E, addr[4]=0).
  - hazard_x_o is masked when lsu_resp_valid_i & ~lsu_resp_err_i.
- Not defined: reads return only the stored array; no masking of hazards.

## Structure
- cve2_pkg holds:
  - typedef rf_sb_state_e {RF_SB_IDLE, RF_SB_PEND};
  - localparam RF_ADDR_W=5.
- One sub-module, cve2_regfile_sb: the scoreboard FSM, pend_addr, issue_err_o, and hazard compare.
- Storage, the write decoder and the read muxes stay in the top module.

## Test plan
- Write x5=0xDEADBEEF, read A=5 next cycle → 0xDEADBEEF; write x0=0x1234 → read x0 = 0.
- With CVE2_RF_FWD_EN, same-cycle write x7=0xA5A5A5A5 with raddr_b=7 → rdata_b=0xA5A5A5A5 that cycle; without the macro → old value.
- load_issue_i with load_waddr_i=9; raddr_a=9 → hazard_a_o=1 and load_pending_o=1 until lsu_resp_valid_i. Error response → FSM to IDLE, x9 unchanged.
- PEND on x3: load_issue_i (x4) without response → issue_err_o pulses 1 cycle, pend_addr stays 3. The same issue coincident with a response → pend_addr=4, no error.
- RV32E=1: write addr 20 → dropped, wr_err_o=1 for one cycle; read addr 20 → 0.
- Assert rst_i while PEND with x1..x31 nonzero → next cycle all reads 0, load_pending_o=0, hazards 0.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared types for the integer register file and its load scoreboard.
package cve2_pkg;

  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic {
    RF_SB_IDLE,
    RF_SB_PEND
  } rf_sb_state_e;

endpackage

// File: rtl/cve2_regfile_sb.sv
// Single-entry load scoreboard: tracks one outstanding load and flags reads of its destination.
// CVE2_RF_FWD_EN: hazards are masked in the cycle a good LSU response arrives.
module cve2_regfile_sb
  import cve2_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_issue_i,
  input  logic [RF_ADDR_W-1:0] load_waddr_i,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  input  logic [RF_ADDR_W-1:0] raddr_a_i,
  input  logic [RF_ADDR_W-1:0] raddr_b_i,
  output logic                 load_pending_o,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 issue_err_o
);

  rf_sb_state_e         state_q, state_d;
  logic [RF_ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic                 issue_err_q, issue_err_d;
  logic                 hazard_en;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    issue_err_d = 1'b0;
    case (state_q)
      RF_SB_IDLE: begin
        if (load_issue_i) begin
          state_d     = RF_SB_PEND;
          pend_addr_d = load_waddr_i;
        end
      end
      RF_SB_PEND: begin
        // The response frees the slot, so a coincident issue takes it over.
        if (lsu_resp_valid_i) begin
          if (load_issue_i) pend_addr_d = load_waddr_i;
          else              state_d     = RF_SB_IDLE;
        end else if (load_issue_i) begin
          issue_err_d = 1'b1;
        end
      end
      default: state_d = RF_SB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RF_SB_IDLE;
      pend_addr_q <= '0;
      issue_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      issue_err_q <= issue_err_d;
    end
  end

`ifdef CVE2_RF_FWD_EN
  // The good response's data is forwarded this cycle, so the reader need not stall.
  assign hazard_en = (state_q == RF_SB_PEND) && (pend_addr_q != '0) &&
                     !(lsu_resp_valid_i && !lsu_resp_err_i);
`else
  logic unused_resp_err;
  assign unused_resp_err = lsu_resp_err_i;
  assign hazard_en = (state_q == RF_SB_PEND) && (pend_addr_q != '0);
`endif

  assign load_pending_o = (state_q == RF_SB_PEND);
  assign hazard_a_o     = hazard_en && (raddr_a_i == pend_addr_q);
  assign hazard_b_o     = hazard_en && (raddr_b_i == pend_addr_q);
  assign issue_err_o    = issue_err_q;

endmodule

// File: rtl/cve2_regfile_wb.sv
// Flip-flop integer register file with writeback sink, two combinational read ports and load scoreboard.
// CVE2_RF_FWD_EN: same-cycle write-to-read forwarding on both read ports.
module cve2_regfile_wb
  import cve2_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [RF_ADDR_W-1:0] rf_waddr_wb_i,
  input  logic [DataWidth-1:0] rf_wdata_wb_i,
  input  logic                 rf_we_wb_i,
  input  logic [RF_ADDR_W-1:0] rf_raddr_a_i,
  input  logic [RF_ADDR_W-1:0] rf_raddr_b_i,
  output logic [DataWidth-1:0] rf_rdata_a_o,
  output logic [DataWidth-1:0] rf_rdata_b_o,
  input  logic                 load_issue_i,
  input  logic [RF_ADDR_W-1:0] load_waddr_i,
  input  logic                 lsu_resp_valid_i,
  input  logic                 lsu_resp_err_i,
  output logic                 load_pending_o,
  output logic                 hazard_a_o,
  output logic                 hazard_b_o,
  output logic                 wr_err_o,
  output logic                 issue_err_o
);

  localparam int unsigned NumRegs = RV32E ? 16 : 32;
  localparam int unsigned IdxW    = RV32E ? 4 : 5;

  logic [DataWidth-1:0] rf_q [NumRegs];
  logic [DataWidth-1:0] rf_d [NumRegs];
  logic                 wr_err_q, wr_err_d;
  logic                 we_ok;

  // In RV32E the upper half of the address space does not exist.
  assign we_ok = rf_we_wb_i && (rf_waddr_wb_i != '0) && !(RV32E && rf_waddr_wb_i[4]);

  always_comb begin
    rf_d = rf_q;
    if (we_ok) rf_d[rf_waddr_wb_i[IdxW-1:0]] = rf_wdata_wb_i;
    rf_d[0]  = '0;
    wr_err_d = RV32E && rf_we_wb_i && rf_waddr_wb_i[4];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      rf_q     <= rf_d;
      wr_err_q <= wr_err_d;
    end
  end

  function automatic logic [DataWidth-1:0] rd_port(input logic [RF_ADDR_W-1:0] addr);
    logic [DataWidth-1:0] val;
    val = rf_q[addr[IdxW-1:0]];
    if (RV32E && addr[4]) val = '0;
`ifdef CVE2_RF_FWD_EN
    if (we_ok && (rf_waddr_wb_i == addr)) val = rf_wdata_wb_i;
`endif
    return val;
  endfunction

  assign rf_rdata_a_o = rd_port(rf_raddr_a_i);
  assign rf_rdata_b_o = rd_port(rf_raddr_b_i);
  assign wr_err_o     = wr_err_q;

  cve2_regfile_sb u_sb (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .load_issue_i     (load_issue_i),
    .load_waddr_i     (load_waddr_i),
    .lsu_resp_valid_i (lsu_resp_valid_i),
    .lsu_resp_err_i   (lsu_resp_err_i),
    .raddr_a_i        (rf_raddr_a_i),
    .raddr_b_i        (rf_raddr_b_i),
    .load_pending_o   (load_pending_o),
    .hazard_a_o       (hazard_a_o),
    .hazard_b_o       (hazard_b_o),
    .issue_err_o      (issue_err_o)
  );

endmodule
